// File: rtl/sort_circuit_pkg.sv
// rtl/sort_circuit_pkg.sv - shared types and constants for the sorter write path
package sort_circuit_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } arb_state_t;

   localparam int RESP_OKAY = 0;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker, first request after last_grant wins
module rr_pick #(
   parameter int NUM_REQ  = 4,
   parameter int IDX_WDTH = 2
) (
   input  logic [NUM_REQ-1:0]  req,
   input  logic [IDX_WDTH-1:0] last_grant,
   output logic                valid,
   output logic [IDX_WDTH-1:0] idx
);

   logic [NUM_REQ-1:0]   mask;
   logic [2*NUM_REQ-1:0] dbl;

   // Lower half keeps only requesters above last_grant; the unmasked upper half
   // supplies the wrap-around, so the lowest set bit overall is the rr winner.
   always_comb begin
      mask = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         mask[i] = (i > int'(last_grant));
      end
      dbl   = {req, req & mask};
      valid = |req;
      idx   = '0;
      for (int j = 2*NUM_REQ-1; j >= 0; j--) begin
         if (dbl[j]) begin
            idx = IDX_WDTH'(j % NUM_REQ);
         end
      end
   end

endmodule

// File: rtl/write_arbiter.sv
// rtl/write_arbiter.sv - round-robin arbiter sharing one write_submodule between requesters
module write_arbiter
   import sort_circuit_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int ADDR_WDTH = 32,
   parameter int DATA_WDTH = 32,
   parameter int RESP_WDTH = 2,
   parameter int ERR_WDTH  = 8
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ*DATA_WDTH-1:0]   req_data,
   input  logic [NUM_REQ*ADDR_WDTH-1:0]   req_addr,
   output logic [NUM_REQ-1:0]             req_done,
   output logic [RESP_WDTH-1:0]           req_resp,
   output logic                           wr_start,
   output logic [DATA_WDTH-1:0]           wr_data,
   output logic [ADDR_WDTH-1:0]           wr_addr,
   input  logic                           wr_done,
   input  logic [RESP_WDTH-1:0]           wr_resp,
   output logic                           busy,
   output logic [$clog2(NUM_REQ)-1:0]     grant_idx,
   output logic [ERR_WDTH-1:0]            err_count
);

   localparam int                  IDX_WDTH = $clog2(NUM_REQ);
   localparam logic [ERR_WDTH-1:0] ERR_MAX  = '1;

   arb_state_t            state;
   logic [IDX_WDTH-1:0]   last_grant;
   logic                  pick_valid;
   logic [IDX_WDTH-1:0]   pick_idx;
   logic [DATA_WDTH-1:0]  pick_data;
   logic [ADDR_WDTH-1:0]  pick_addr;
   logic                  resp_err;

   rr_pick #(
      .NUM_REQ  (NUM_REQ),
      .IDX_WDTH (IDX_WDTH)
   ) u_pick (
      .req        (req_valid),
      .last_grant (last_grant),
      .valid      (pick_valid),
      .idx        (pick_idx)
   );

   always_comb begin
      pick_data = '0;
      pick_addr = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick_idx == IDX_WDTH'(i)) begin
            pick_data = req_data[i*DATA_WDTH +: DATA_WDTH];
            pick_addr = req_addr[i*ADDR_WDTH +: ADDR_WDTH];
         end
      end
   end

   assign resp_err = (wr_resp != RESP_WDTH'(RESP_OKAY));
   assign wr_start = (state == ISSUE);
   assign busy     = (state != IDLE);

   // last_grant starts at the top index so requester 0 wins the first round.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= IDX_WDTH'(NUM_REQ-1);
         grant_idx  <= '0;
         wr_data    <= '0;
         wr_addr    <= '0;
         req_done   <= '0;
         req_resp   <= '0;
         err_count  <= '0;
      end else begin
         req_done <= '0;
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  grant_idx <= pick_idx;
                  wr_data   <= pick_data;
                  wr_addr   <= pick_addr;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               state <= WAIT;
            end
            WAIT: begin
               if (wr_done) begin
                  req_done   <= NUM_REQ'(1) << grant_idx;
                  req_resp   <= wr_resp;
                  last_grant <= grant_idx;
                  if (resp_err && (err_count != ERR_MAX)) begin
                     err_count <= err_count + ERR_WDTH'(1);
                  end
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
